mdu_controller: RTL

Sequencing controller for the multiply/divide unit (MDU) in the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and holds the HI/LO architectural registers. Multiply and divide run as fixed-latency multi-cycle operations. The block raises a stall request that the pipeline stall controller turns into PC/IF_ID freeze and ID_EX bubble insertion while an ID-stage instruction needs the MDU.

---
 rtl/mdu_controller_pkg.sv | 20 ++
 rtl/mdu_core.sv | 51 +++++
 rtl/mdu_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/mdu_controller_pkg.sv
// Shared MDU opcode encodings, default latencies and sequencing state type.
package mdu_controller_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {StIdle, StRun} mdu_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational MDU datapath: 64-bit products and quotient/remainder with the
// divide-by-zero result convention.
module mdu_core
  import mdu_controller_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, mag_q, mag_r, sq, sr, uq, ur;

  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign abs_a = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign abs_b = b_i[31] ? (~b_i + 32'd1) : b_i;
  assign mag_q = abs_a / abs_b;
  assign mag_r = abs_a % abs_b;
  // 0x8000_0000 / -1 falls out of the magnitude path: |q| = 2^31 negates to itself.
  assign sq    = (a_i[31] ^ b_i[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sr    = a_i[31] ? (~mag_r + 32'd1) : mag_r;
  assign uq    = a_i / b_i;
  assign ur    = a_i % b_i;

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MDU_MULT:  {hi_o, lo_o} = prod_s;
      MDU_MULTU: {hi_o, lo_o} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b_i == 32'd0) begin
          hi_o = a_i;
          lo_o = 32'hFFFF_FFFF;
        end else if (op_i == MDU_DIV) begin
          hi_o = sr;
          lo_o = sq;
        end else begin
          hi_o = ur;
          lo_o = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// MDU sequencer: holds HI/LO, runs fixed-latency mul/div with a down-counter and
// raises the pipeline stall request.
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        id_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] core_hi, core_lo;
  mdu_state_e  state;

  mdu_core u_core (
    .op_i (op),
    .a_i  (rs_data),
    .b_i  (rt_data),
    .hi_o (core_hi),
    .lo_o (core_lo)
  );

  // The counter is the state: zero means idle.
  assign state = (cnt_q == 4'd0) ? StIdle : StRun;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state)
      StIdle: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_d = core_hi;
              pend_lo_d = core_lo;
              cnt_d     = MultLoad;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_hi_d = core_hi;
              pend_lo_d = core_lo;
              cnt_d     = DivLoad;
            end
            MDU_MTHI: hi_d = rs_data;
            MDU_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy     = (state == StRun);
  assign md_stall = id_md_use & (busy | (start & is_muldiv(op)));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
